multicycle_controller: RTL

- Control FSM for the multicycle version of the processor.
- Sequences one shared ALU, one shared memory port and the register file over several cycles per instruction.
- Supported instructions: ADD, SUB, AND, ORR, LSL, LSR, CMP, LDR, STR.
- Memory accesses use a ready handshake with a watchdog timeout; the block emits per-cycle datapath strobes and selects.

---
 rtl/multicycle_controller.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multicycle processor control FSM: sequences the shared ALU, memory port
// and register file, with a ready handshake and wait watchdog on memory.
module multicycle_controller #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] Op,
   input  logic [5:0] Funct,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       MemW,
   output logic       RegW,
   output logic       FlagW,
   output logic       RegSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ALUOp,
   output logic       shift_right_left,
   output logic [1:0] ResultSrc,
   output logic       InstrDone,
   output logic       Illegal,
   output logic       BusErr,
   output logic [3:0] State
);

   // state    | meaning
   // FETCH    | read instruction at PC, PC <= PC+4 on ready
   // DECODE   | classify Op/Funct, latch class
   // MEMADR   | ALUOut <= base + Imm12
   // MEMREAD  | load access, wait for ready
   // MEMWB    | write loaded data to register file
   // MEMWRITE | store access, wait for ready
   // EXECR    | register ALU op (CMP finishes here)
   // EXECS    | shift op
   // ALUWB    | write ALU/shifter result
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECS    = 4'd7,
      S_ALUWB    = 4'd8
   } state_t;

   typedef enum logic [2:0] {
      C_NONE = 3'd0,
      C_ALU  = 3'd1,
      C_CMP  = 3'd2,
      C_LSL  = 3'd3,
      C_LSR  = 3'd4,
      C_LDR  = 3'd5,
      C_STR  = 3'd6,
      C_ILL  = 3'd7
   } cls_t;

   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t     state_q, state_d;
   cls_t       cls_q, cls_d, dec_cls;
   logic [7:0] wait_q, wait_d;
   logic       wait_st, timeout;
   logic       pcw, irw, memw, regw, flagw, done, ill, berr;

   // classify the instruction fields presented by the IR
   always_comb begin
      dec_cls = C_ILL;
      if (Op == 2'b00) begin
         if (!Funct[5]) begin
            case (Funct[4:1])
               4'b0100, 4'b0010, 4'b0000, 4'b1100: dec_cls = C_ALU;
               4'b1010:                            dec_cls = C_CMP;
               default:                            dec_cls = C_ILL;
            endcase
         end else begin
            case (Funct[4:1])
               4'b1000: dec_cls = C_LSL;
               4'b0001: dec_cls = C_LSR;
               default: dec_cls = C_ILL;
            endcase
         end
      end else if (Op == 2'b01) begin
         dec_cls = Funct[0] ? C_LDR : C_STR;
      end
   end

   assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                    (state_q == S_MEMWRITE);
   // abort on the cycle the count would reach MAX_WAIT without ready
   assign timeout = wait_st && !MemReady && (wait_q == WAIT_LAST);

   // wait counter: only ever nonzero while stalled in a wait state
   always_comb begin
      wait_d = 8'd0;
      if (wait_st && !MemReady && !timeout) wait_d = wait_q + 8'd1;
   end

   // next state, selects and raw strobes
   always_comb begin
      state_d          = state_q;
      cls_d            = cls_q;
      pcw              = 1'b0;
      irw              = 1'b0;
      memw             = 1'b0;
      regw             = 1'b0;
      flagw            = 1'b0;
      done             = 1'b0;
      ill              = 1'b0;
      berr             = timeout;
      AdrSrc           = 1'b0;
      RegSrc           = 1'b0;
      ALUSrcA          = 1'b0;
      ALUSrcB          = 2'b00;
      ALUOp            = 1'b0;
      shift_right_left = 1'b0;
      ResultSrc        = 2'b00;
      case (state_q)
         S_FETCH: begin
            ALUSrcA   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            pcw       = MemReady;
            irw       = MemReady;
            if (MemReady) state_d = S_DECODE;
            else if (timeout) state_d = S_FETCH;
         end
         S_DECODE: begin
            cls_d  = dec_cls;
            RegSrc = (dec_cls == C_CMP) || (dec_cls == C_STR);
            case (dec_cls)
               C_ALU, C_CMP: state_d = S_EXECR;
               C_LSL, C_LSR: state_d = S_EXECS;
               C_LDR, C_STR: state_d = S_MEMADR;
               default: begin
                  ill     = 1'b1;
                  done    = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcB = 2'b01;
            RegSrc  = (cls_q == C_STR);
            state_d = (cls_q == C_LDR) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            if (MemReady) state_d = S_MEMWB;
            else if (timeout) state_d = S_FETCH;
         end
         S_MEMWB: begin
            ResultSrc = 2'b01;
            regw      = 1'b1;
            done      = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc = 1'b1;
            RegSrc = 1'b1;
            memw   = !timeout;
            if (MemReady) begin
               done    = 1'b1;
               state_d = S_FETCH;
            end else if (timeout) begin
               state_d = S_FETCH;
            end
         end
         S_EXECR: begin
            ALUOp = 1'b1;
            if (cls_q == C_CMP) begin
               RegSrc  = 1'b1;
               flagw   = 1'b1;
               done    = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_ALUWB;
            end
         end
         S_EXECS: begin
            shift_right_left = (cls_q == C_LSR);
            state_d          = S_ALUWB;
         end
         S_ALUWB: begin
            shift_right_left = (cls_q == C_LSR);
            ResultSrc        = ((cls_q == C_LSL) || (cls_q == C_LSR)) ? 2'b11 : 2'b00;
            regw             = 1'b1;
            done             = 1'b1;
            state_d          = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // state, class and wait counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cls_q   <= C_NONE;
         wait_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         wait_q  <= wait_d;
      end
   end

   // strobes are forced low for as long as reset is held
   assign PCWrite   = pcw & rst_n;
   assign IRWrite   = irw & rst_n;
   assign MemW      = memw & rst_n;
   assign RegW      = regw & rst_n;
   assign FlagW     = flagw & rst_n;
   assign InstrDone = done & rst_n;
   assign Illegal   = ill & rst_n;
   assign BusErr    = berr & rst_n;
   assign State     = state_q;

endmodule
